// File: rtl/dht11_sensor_emu.sv
// rtl/dht11_sensor_emu.sv - DHT11 sensor responder on an open-drain bus; DHT11_EMU_CHKSUM_ERR_EN adds corrupt_chk
module dht11_sensor_emu #(
   parameter int CLK_PER_US    = 100,
   parameter int START_MIN_US  = 18000,
   parameter int RESP_DELAY_US = 30,
   parameter int RESP_LOW_US   = 80,
   parameter int RESP_HIGH_US  = 80,
   parameter int BIT_LOW_US    = 50,
   parameter int BIT0_HIGH_US  = 26,
   parameter int BIT1_HIGH_US  = 70
) (
   input  logic       clk,
   input  logic       reset_p,
   inout  wire        dht11_data,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_dec,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_dec,
`ifdef DHT11_EMU_CHKSUM_ERR_EN
   input  logic       corrupt_chk,
`endif
   output logic       busy,
   output logic       frame_done
);

   localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_US - 1);
   localparam logic [14:0] START_MIN_C  = 15'(START_MIN_US);
   localparam logic [14:0] RESP_DLY_C   = 15'(RESP_DELAY_US);
   localparam logic [14:0] RESP_LOW_C   = 15'(RESP_LOW_US);
   localparam logic [14:0] RESP_HIGH_C  = 15'(RESP_HIGH_US);
   localparam logic [14:0] BIT_LOW_C    = 15'(BIT_LOW_US);
   localparam logic [14:0] BIT0_HIGH_C  = 15'(BIT0_HIGH_US);
   localparam logic [14:0] BIT1_HIGH_C  = 15'(BIT1_HIGH_US);

   typedef enum logic [2:0] {
      S_IDLE, S_START_LOW, S_RESP_WAIT, S_RESP_LOW,
      S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        sync_q, sync_d;
   logic              prev_q, prev_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [14:0]       cnt_q, cnt_d;
   logic [5:0]        bit_idx_q, bit_idx_d;
   logic [39:0]       frame_q, frame_d;
   logic              drive_low_q, drive_low_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              bus_in;
   logic              tick;
   logic              negedge_s, posedge_s;
   logic [14:0]       phase_len;
   logic              phase_done;
   logic [7:0]        chk_byte;

   // Open-drain driver: only ever pull low or release
   assign dht11_data = drive_low_q ? 1'b0 : 1'bz;
   assign busy       = busy_q;
   assign frame_done = done_q;

   // Anything other than a solid 0 on the wire (Z, X, 1) counts as high
   always_comb begin
      bus_in = 1'b1;
      case (dht11_data)
         1'b0:    bus_in = 1'b0;
         default: bus_in = 1'b1;
      endcase
   end

   // Edge detection on the synchronized bus level
   always_comb begin
      sync_d    = {sync_q[0], bus_in};
      prev_d    = sync_q[1];
      negedge_s = prev_q & ~sync_q[1];
      posedge_s = ~prev_q & sync_q[1];
      tick      = (pre_q == PRE_MAX);
   end

   // Checksum of the live inputs, captured together with the data at start acceptance
   always_comb begin
      chk_byte = hum_int + hum_dec + temp_int + temp_dec;
`ifdef DHT11_EMU_CHKSUM_ERR_EN
      if (corrupt_chk) chk_byte = ~chk_byte;
`endif
   end

   // Next-state logic: phase sequencing, bit serialisation and usec timing
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_idx_d = bit_idx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      phase_len = 15'd1;
      case (state_q)
         S_RESP_WAIT: phase_len = RESP_DLY_C;
         S_RESP_LOW:  phase_len = RESP_LOW_C;
         S_RESP_HIGH: phase_len = RESP_HIGH_C;
         S_BIT_LOW:   phase_len = BIT_LOW_C;
         S_END_LOW:   phase_len = BIT_LOW_C;
         S_BIT_HIGH:  phase_len = frame_q[39] ? BIT1_HIGH_C : BIT0_HIGH_C;
         default:     phase_len = 15'd1;
      endcase
      // Phase ends on the tick that completes its N-th microsecond
      phase_done = tick && (cnt_q >= phase_len - 15'd1);

      case (state_q)
         S_IDLE: begin
            if (negedge_s) state_d = S_START_LOW;
         end
         S_START_LOW: begin
            if (posedge_s) begin
               if (cnt_q >= START_MIN_C) begin
                  frame_d = {hum_int, hum_dec, temp_int, temp_dec, chk_byte};
                  busy_d  = 1'b1;
                  state_d = S_RESP_WAIT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_RESP_WAIT: if (phase_done) state_d = S_RESP_LOW;
         S_RESP_LOW:  if (phase_done) state_d = S_RESP_HIGH;
         S_RESP_HIGH: begin
            if (phase_done) begin
               bit_idx_d = 6'd0;
               state_d   = S_BIT_LOW;
            end
         end
         S_BIT_LOW:   if (phase_done) state_d = S_BIT_HIGH;
         S_BIT_HIGH: begin
            if (phase_done) begin
               frame_d   = {frame_q[38:0], 1'b0};
               bit_idx_d = bit_idx_q + 6'd1;
               state_d   = (bit_idx_d == 6'd40) ? S_END_LOW : S_BIT_LOW;
            end
         end
         S_END_LOW: begin
            if (phase_done) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Timebase restarts on every phase change so each phase is measured from its own start
      if (state_d != state_q) begin
         pre_d = '0;
         cnt_d = '0;
      end else begin
         pre_d = tick ? '0 : pre_q + 1'b1;
         cnt_d = (tick && (cnt_q != 15'h7fff)) ? cnt_q + 15'd1 : cnt_q;
      end

      drive_low_d = (state_d == S_RESP_LOW) || (state_d == S_BIT_LOW) || (state_d == S_END_LOW);
   end

   // State and output registers; async reset releases the bus immediately
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q     <= S_IDLE;
         sync_q      <= 2'b00;
         prev_q      <= 1'b0;
         pre_q       <= '0;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         frame_q     <= '0;
         drive_low_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         prev_q      <= prev_d;
         pre_q       <= pre_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         frame_q     <= frame_d;
         drive_low_q <= drive_low_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb/tb_dht11_sensor_emu.sv - scoreboard bench for dht11_sensor_emu with a host-side bus monitor
`timescale 1ns/1ps
module tb_dht11_sensor_emu;

   localparam int CPU  = 2;
   localparam int SMIN = 40;
   localparam int RD   = 6;
   localparam int RL   = 16;
   localparam int RH   = 16;
   localparam int BL   = 10;
   localparam int B0   = 5;
   localparam int B1   = 14;
   localparam int THR  = (B0 + B1) * CPU / 2;

   logic       clk = 1'b0;
   logic       reset_p = 1'b1;
   logic       host_low = 1'b0;
   logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
   logic       busy, frame_done;
   wire        dht11_data;
`ifdef DHT11_EMU_CHKSUM_ERR_EN
   logic       corrupt_v = 1'b0;
`endif

   assign dht11_data = host_low ? 1'b0 : 1'bz;
   pullup (dht11_data);

   always #5 clk = ~clk;

   dht11_sensor_emu #(
      .CLK_PER_US(CPU), .START_MIN_US(SMIN), .RESP_DELAY_US(RD), .RESP_LOW_US(RL),
      .RESP_HIGH_US(RH), .BIT_LOW_US(BL), .BIT0_HIGH_US(B0), .BIT1_HIGH_US(B1)
   ) dut (
      .clk(clk), .reset_p(reset_p), .dht11_data(dht11_data),
      .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
`ifdef DHT11_EMU_CHKSUM_ERR_EN
      .corrupt_chk(corrupt_v),
`endif
      .busy(busy), .frame_done(frame_done)
   );

   int checks = 0, errors = 0;
   logic [39:0] exp_q[$];
   int exp_frames = 0;

   int cyc = 0, rel_cyc = 0, mon_ph = 0, mon_nbits = 0, run = 0;
   int frames_seen = 0, done_pulses = 0;
   bit lvl = 1'b0, prev_lvl = 1'b0;
   logic [39:0] acc = '0, last_frame = '0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   task automatic chk_rng(input string name, input int got, input int lo, input int hi);
      checks++;
      if (got < lo || got > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   // Reference: five bytes, checksum is the byte sum modulo 256, optionally inverted
   function automatic logic [39:0] model(input int a, input int b, input int c, input int d, input bit corrupt);
      int s;
      logic [7:0] ck;
      s  = (a + b + c + d) % 256;
      ck = 8'(s);
      if (corrupt) ck = 8'(255 - s);
      return {8'(a), 8'(b), 8'(c), 8'(d), ck};
   endfunction

   // A phase of N us must last between (N-1) us and N us plus one clock
   task automatic end_run(input bit was_low, input int len);
      logic [39:0] f;
      bit eb;
      case (mon_ph)
         0: if (!was_low) begin
               chk_rng("resp_delay", cyc - rel_cyc, (RD - 1) * CPU, RD * CPU + 5);
               chk("busy_in_frame", 64'(busy), 64'd1);
               mon_ph = 1;
            end
         1: begin chk_rng("resp_low", len, (RL - 1) * CPU, RL * CPU + 1); mon_ph = 2; end
         2: begin
               chk_rng("resp_high", len, (RH - 1) * CPU, RH * CPU + 1);
               mon_ph = 3; mon_nbits = 0; acc = '0;
            end
         3: begin
               if (mon_nbits < 40) begin
                  chk_rng("bit_low", len, (BL - 1) * CPU, BL * CPU + 1);
                  mon_ph = 4;
               end else begin
                  chk_rng("end_low", len, (BL - 1) * CPU, BL * CPU + 1);
                  chk("frame_done_at_release", 64'(frame_done), 64'd1);
                  chk("busy_after_frame", 64'(busy), 64'd0);
                  if (exp_q.size() == 0) chk("unexpected_frame", 64'(acc), 64'd0 - 64'd1);
                  else begin
                     f = exp_q.pop_front();
                     chk("frame", 64'(acc), 64'(f));
                  end
                  last_frame = acc;
                  frames_seen++;
                  mon_ph = 0;
               end
            end
         4: begin
               acc = {acc[38:0], (len > THR)};
               if (exp_q.size() > 0) begin
                  f  = exp_q[0];
                  eb = f[39 - mon_nbits];
                  chk_rng("bit_high", len, ((eb ? B1 : B0) - 1) * CPU, (eb ? B1 : B0) * CPU + 1);
               end
               mon_nbits++;
               mon_ph = 3;
            end
         default: mon_ph = 0;
      endcase
   endtask

   // Monitor: segments the sensor-driven waveform into runs and scores each phase
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (frame_done === 1'b1) done_pulses++;
         lvl = (dht11_data === 1'b0) && !host_low;
         if (reset_p) begin
            mon_ph = 0; run = 0; prev_lvl = 1'b0;
         end else if (lvl != prev_lvl) begin
            end_run(prev_lvl, run);
            run = 1;
            prev_lvl = lvl;
         end else begin
            run++;
         end
      end
   end

   task automatic host_start(input int us);
      @(posedge clk); #3;
      host_low = 1'b1;
      repeat (us * CPU) @(posedge clk);
      #3;
      host_low = 1'b0;
      rel_cyc = cyc;
   endtask

   task automatic wait_frame(input int target);
      int n = 0;
      while (frames_seen < target && n < 20000) begin @(negedge clk); n++; end
      chk("frame_arrived", 64'(frames_seen), 64'(target));
   endtask

   task automatic set_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input bit corrupt);
      hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
`ifdef DHT11_EMU_CHKSUM_ERR_EN
      corrupt_v = corrupt;
`endif
      exp_q.push_back(model(a, b, c, d, corrupt));
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input bit corrupt);
      set_bytes(a, b, c, d, corrupt);
      exp_frames++;
      host_start(SMIN + 5);
      wait_frame(exp_frames);
      repeat (10 * CPU) @(posedge clk);
   endtask

   // Watches a window after a start that must be ignored: no sensor drive, busy never set
   task automatic expect_silence(input string name);
      int seen = 0;
      int fs = frames_seen;
      repeat ((RD + RL + 20) * CPU) begin
         @(negedge clk); #1;
         if (busy !== 1'b0 || lvl) seen++;
      end
      chk(name, 64'(seen), 64'd0);
      chk({name, "_frames"}, 64'(frames_seen), 64'(fs));
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_frame_done", 64'(frame_done), 64'd0);
      chk("reset_bus", 64'(dht11_data === 1'b0), 64'd0);
      #2 reset_p = 1'b0;
      repeat (5 * CPU) @(posedge clk);

      // Basic frame
      run_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
      chk("chk_byte_0x50", 64'(last_frame[7:0]), 64'h50);

      // Short pulse is ignored, then a normal start is answered
      host_start(SMIN / 4);
      expect_silence("short_pulse_silent");
      run_frame(8'h41, 8'h02, 8'h17, 8'h05, 1'b0);

      // All-ones data: checksum wraps
      run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      chk("chk_byte_0xfc", 64'(last_frame[7:0]), 64'hFC);

      // Input change mid-frame does not reach the wire
      set_bytes(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
      exp_frames++;
      host_start(SMIN + 5);
      n = 0;
      while (!(mon_ph != 0 && mon_nbits >= 10) && n < 20000) begin @(negedge clk); #1; n++; end
      chk("reached_bit10", 64'(n < 20000), 64'd1);
      temp_int = 8'h20;
      wait_frame(exp_frames);
      chk("snapshot_temp_int", 64'(last_frame[23:16]), 64'h19);
      repeat (10 * CPU) @(posedge clk);

      // Reset during the low lead-in of bit 20
      set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      host_start(SMIN + 5);
      n = 0;
      while (!(mon_ph == 3 && mon_nbits == 20 && lvl) && n < 20000) begin @(negedge clk); #1; n++; end
      chk("reached_bit20_low", 64'(n < 20000), 64'd1);
      #2 reset_p = 1'b1;
      #1;
      chk("reset_releases_bus", 64'(dht11_data === 1'b0), 64'd0);
      chk("reset_clears_busy", 64'(busy), 64'd0);
      void'(exp_q.pop_front());
      repeat (3) @(posedge clk);
      #3 reset_p = 1'b0;
      repeat (5 * CPU) @(posedge clk);
      run_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);

      // Bus already low when reset is released is not a start
      @(posedge clk); #3;
      host_low = 1'b1;
      reset_p  = 1'b1;
      repeat (3) @(posedge clk);
      #3 reset_p = 1'b0;
      repeat ((SMIN + 10) * CPU) @(posedge clk);
      #3 host_low = 1'b0;
      rel_cyc = cyc;
      expect_silence("low_at_reset_silent");
      run_frame(8'h05, 8'h06, 8'h07, 8'h08, 1'b0);

      // Randomized frames
      for (int i = 0; i < 4; i++)
         run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);

`ifdef DHT11_EMU_CHKSUM_ERR_EN
      run_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b1);
      chk("corrupt_chk_0xaf", 64'(last_frame[7:0]), 64'hAF);
      run_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
`endif

      repeat (5 * CPU) @(posedge clk);
      chk("frame_done_pulses", 64'(done_pulses), 64'(exp_frames));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
